// File: rtl/acc_source_selector_if.sv
// Bus bundle for the accumulator source selector: packed sources, select and
// write controls in one direction, mux view, accumulator and status back.
interface acc_source_selector_if #(
  parameter int unsigned E_BITS = 16,
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned S_BITS = 2
);
  logic [N_SRC*E_BITS-1:0] i_src;
  logic [S_BITS-1:0]       i_sel;
  logic                    i_wr_acc;
  logic                    i_clr_err;
  logic [E_BITS-1:0]       o_mux;
  logic [E_BITS-1:0]       o_acc;
  logic                    o_acc_zero;
  logic                    o_acc_neg;
  logic                    o_pending;
  logic                    o_sel_err;

  // Datapath controller side: drives sources and strobes, observes ACC.
  modport master (
    output i_src, i_sel, i_wr_acc, i_clr_err,
    input  o_mux, o_acc, o_acc_zero, o_acc_neg, o_pending, o_sel_err
  );

  // Selector side.
  modport slave (
    input  i_src, i_sel, i_wr_acc, i_clr_err,
    output o_mux, o_acc, o_acc_zero, o_acc_neg, o_pending, o_sel_err
  );
endinterface

// File: rtl/acc_source_selector.sv
// Accumulator input selector: picks one of N_SRC sources and loads it into the
// accumulator on a write strobe, optionally through one register stage.
// Writes with an out-of-range select are dropped and raise a sticky error.
module acc_source_selector #(
  parameter int unsigned E_BITS = 16,
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned S_BITS = 2,
  parameter int unsigned PIPE   = 1
) (
  input logic                  i_clock,
  input logic                  i_reset,
  acc_source_selector_if.slave bus
);

  logic [E_BITS-1:0] mux;
  logic              sel_legal;
  logic              legal_wr;
  logic [E_BITS-1:0] acc_q;
  logic              err_q, err_d;

  assign sel_legal = 32'(bus.i_sel) < N_SRC;
  assign legal_wr  = bus.i_wr_acc & sel_legal;

  // Source mux; an out-of-range select yields zero.
  always_comb begin
    mux = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (bus.i_sel == S_BITS'(k)) begin
        mux = bus.i_src[k*E_BITS +: E_BITS];
      end
    end
  end

  // Sticky select error; a new illegal write beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (bus.i_clr_err) begin
      err_d = 1'b0;
    end
    if (bus.i_wr_acc && !sel_legal) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic [E_BITS-1:0] stage_q;
    logic              pend_q;

    // Stage 1 captures legal writes; idle or illegal cycles leave data and drop pending.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        stage_q <= '0;
        pend_q  <= 1'b0;
      end else begin
        pend_q <= legal_wr;
        if (legal_wr) begin
          stage_q <= mux;
        end
      end
    end

    // ACC takes stage 1 one edge after capture, so back-to-back writes stream.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        acc_q <= '0;
      end else if (pend_q) begin
        acc_q <= stage_q;
      end
    end

    assign bus.o_pending = pend_q;
  end else begin : g_direct
    // ACC loads the selected source directly on a legal write.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        acc_q <= '0;
      end else if (legal_wr) begin
        acc_q <= mux;
      end
    end

    assign bus.o_pending = 1'b0;
  end

  assign bus.o_mux      = mux;
  assign bus.o_acc      = acc_q;
  assign bus.o_acc_zero = (acc_q == '0);
  assign bus.o_acc_neg  = acc_q[E_BITS-1];
  assign bus.o_sel_err  = err_q;

endmodule

// File: tb/tb_acc_source_selector.sv
// Bench for acc_source_selector: a PIPE=0 and a PIPE=1 instance share stimulus.
// Directed vector table first, then random traffic against a queue-based model.
module tb_acc_source_selector;
  localparam int unsigned EB = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned SB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_source_selector_if #(.E_BITS(EB), .N_SRC(NS), .S_BITS(SB)) bus0 ();
  acc_source_selector_if #(.E_BITS(EB), .N_SRC(NS), .S_BITS(SB)) bus1 ();

  acc_source_selector #(.E_BITS(EB), .N_SRC(NS), .S_BITS(SB), .PIPE(0)) dut0 (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus0)
  );

  acc_source_selector #(.E_BITS(EB), .N_SRC(NS), .S_BITS(SB), .PIPE(1)) dut1 (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [47:0] src, input logic [1:0] sel, input logic wr,
                       input logic clr, input logic r);
    bus0.i_src = src; bus0.i_sel = sel; bus0.i_wr_acc = wr; bus0.i_clr_err = clr;
    bus1.i_src = src; bus1.i_sel = sel; bus1.i_wr_acc = wr; bus1.i_clr_err = clr;
    rst = r;
  endtask

  // Expected values are the state after the edge at which the row was applied.
  typedef struct {
    logic [47:0] src;
    logic [1:0]  sel;
    logic        wr, clr, rst;
    logic [15:0] acc0, acc1;
    logic        pend1, err;
    logic [15:0] mux;
  } vec_t;

  function automatic vec_t mk(logic [47:0] src, logic [1:0] sel, logic wr, logic clr,
                              logic r, logic [15:0] acc0, logic [15:0] acc1, logic pend1,
                              logic err, logic [15:0] mux);
    vec_t v;
    v.src = src; v.sel = sel; v.wr = wr; v.clr = clr; v.rst = r;
    v.acc0 = acc0; v.acc1 = acc1; v.pend1 = pend1; v.err = err; v.mux = mux;
    return v;
  endfunction

  function automatic logic [15:0] lane(logic [47:0] src, int k);
    return src[k*16 +: 16];
  endfunction

  // Packed as {alu, ext, ram}.
  localparam logic [47:0] SA = {16'h0002, 16'h0000, 16'h0001};
  localparam logic [47:0] SBV = {16'h8000, 16'h0000, 16'h0001};
  localparam logic [47:0] SC = {16'h8000, 16'h00AA, 16'h0001};

  vec_t vecs[$];

  // Random-phase reference state.
  logic [15:0] m_acc0, m_acc1, m_mux;
  logic        m_err;
  logic [15:0] m_q[$];

  task automatic check_all(input string tag, input logic [15:0] a0, input logic [15:0] a1,
                           input logic p1, input logic e);
    chk({tag, " acc0"}, bus0.o_acc, a0);
    chk({tag, " acc1"}, bus1.o_acc, a1);
    chk({tag, " pend0"}, bus0.o_pending, 1'b0);
    chk({tag, " pend1"}, bus1.o_pending, p1);
    chk({tag, " err0"}, bus0.o_sel_err, e);
    chk({tag, " err1"}, bus1.o_sel_err, e);
    chk({tag, " zero0"}, bus0.o_acc_zero, a0 == 16'h0);
    chk({tag, " zero1"}, bus1.o_acc_zero, a1 == 16'h0);
    chk({tag, " neg0"}, bus0.o_acc_neg, a0[15]);
    chk({tag, " neg1"}, bus1.o_acc_neg, a1[15]);
  endtask

  initial begin
    // reset / idle mux sweep
    vecs.push_back(mk(SA, 2'd0, 0, 0, 1, 16'h0, 16'h0, 0, 0, 16'h0001));
    vecs.push_back(mk(SA, 2'd0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0001));
    vecs.push_back(mk(SA, 2'd1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0000));
    vecs.push_back(mk(SA, 2'd2, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0002));
    // back-to-back writes sel 2,0,2
    vecs.push_back(mk(SA, 2'd2, 1, 0, 0, 16'h2, 16'h0, 1, 0, 16'h0002));
    vecs.push_back(mk(SA, 2'd0, 1, 0, 0, 16'h1, 16'h2, 1, 0, 16'h0001));
    vecs.push_back(mk(SA, 2'd2, 1, 0, 0, 16'h2, 16'h1, 1, 0, 16'h0002));
    vecs.push_back(mk(SA, 2'd0, 0, 0, 0, 16'h2, 16'h2, 0, 0, 16'h0001));
    // negative value
    vecs.push_back(mk(SBV, 2'd2, 1, 0, 0, 16'h8000, 16'h2, 1, 0, 16'h8000));
    vecs.push_back(mk(SBV, 2'd2, 0, 0, 0, 16'h8000, 16'h8000, 0, 0, 16'h8000));
    // illegal select, clear, set-wins
    vecs.push_back(mk(SBV, 2'd3, 1, 0, 0, 16'h8000, 16'h8000, 0, 1, 16'h0000));
    vecs.push_back(mk(SBV, 2'd3, 0, 1, 0, 16'h8000, 16'h8000, 0, 0, 16'h0000));
    vecs.push_back(mk(SBV, 2'd3, 1, 1, 0, 16'h8000, 16'h8000, 0, 1, 16'h0000));
    vecs.push_back(mk(SBV, 2'd0, 0, 1, 0, 16'h8000, 16'h8000, 0, 0, 16'h0001));
    // reset discards pending write
    vecs.push_back(mk(SC, 2'd1, 1, 0, 0, 16'h00AA, 16'h8000, 1, 0, 16'h00AA));
    vecs.push_back(mk(SC, 2'd1, 0, 0, 1, 16'h0, 16'h0, 0, 0, 16'h00AA));
    vecs.push_back(mk(SC, 2'd0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0001));
    // load, then idle sweep 0..3
    vecs.push_back(mk(SC, 2'd0, 1, 0, 0, 16'h1, 16'h0, 1, 0, 16'h0001));
    vecs.push_back(mk(SC, 2'd0, 0, 0, 0, 16'h1, 16'h1, 0, 0, 16'h0001));
    vecs.push_back(mk(SC, 2'd1, 0, 0, 0, 16'h1, 16'h1, 0, 0, 16'h00AA));
    vecs.push_back(mk(SC, 2'd2, 0, 0, 0, 16'h1, 16'h1, 0, 0, 16'h8000));
    vecs.push_back(mk(SC, 2'd3, 0, 0, 0, 16'h1, 16'h1, 0, 0, 16'h0000));
    // pending write completes across an illegal write
    vecs.push_back(mk(SC, 2'd2, 1, 0, 0, 16'h8000, 16'h1, 1, 0, 16'h8000));
    vecs.push_back(mk(SC, 2'd3, 1, 0, 0, 16'h8000, 16'h8000, 0, 1, 16'h0000));
    vecs.push_back(mk(SC, 2'd0, 0, 1, 0, 16'h8000, 16'h8000, 0, 0, 16'h0001));

    drive(48'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    foreach (vecs[i]) begin
      drive(vecs[i].src, vecs[i].sel, vecs[i].wr, vecs[i].clr, vecs[i].rst);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].acc0, vecs[i].acc1, vecs[i].pend1,
                vecs[i].err);
      chk($sformatf("vec%0d mux0", i), bus0.o_mux, vecs[i].mux);
      chk($sformatf("vec%0d mux1", i), bus1.o_mux, vecs[i].mux);
    end

    // Random phase: start from a reset so the model is in sync.
    drive(48'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    m_acc0 = '0; m_acc1 = '0; m_err = 1'b0; m_q.delete();
    for (int i = 0; i < 500; i++) begin
      logic [47:0] src;
      logic [1:0]  sel;
      logic        wr, clr, r, legal;
      src = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 4) == 0) src[15:0] = 16'h0;
      sel = 2'($urandom_range(0, 3));
      wr  = $urandom_range(0, 2) != 0;
      clr = $urandom_range(0, 5) == 0;
      r   = $urandom_range(0, 40) == 0;
      drive(src, sel, wr, clr, r);
      legal = (int'(sel) < NS);
      m_mux = legal ? lane(src, int'(sel)) : 16'h0;
      #1;
      chk($sformatf("rnd%0d mux0", i), bus0.o_mux, m_mux);
      chk($sformatf("rnd%0d mux1", i), bus1.o_mux, m_mux);
      if (r) begin
        m_acc0 = '0; m_acc1 = '0; m_err = 1'b0; m_q.delete();
      end else begin
        if (wr && legal) m_acc0 = m_mux;
        if (m_q.size() != 0) m_acc1 = m_q.pop_front();
        if (wr && legal) m_q.push_back(m_mux);
        if (wr && !legal) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
      end
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i), m_acc0, m_acc1, m_q.size() != 0, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
